// File: rtl/selector_pkg.sv
// Shared router definitions: port count, port indices and select-vector helpers
// used by every column of the 5-port crossbar.
package selector_pkg;

    localparam int unsigned NUM_PORTS = 5;

    localparam int unsigned PORT_LOCAL = 0;
    localparam int unsigned PORT_N     = 1;
    localparam int unsigned PORT_E     = 2;
    localparam int unsigned PORT_S     = 3;
    localparam int unsigned PORT_W     = 4;

    typedef logic [NUM_PORTS-1:0] sel_t;

    localparam sel_t SEL_NONE = 5'b00000;
    localparam sel_t SEL_ONE  = 5'b00001;

    // True when at most one bit of v is set; a legal crossbar select.
    function automatic logic sel_is_legal(input sel_t v);
        sel_is_legal = ((v & (v - SEL_ONE)) == SEL_NONE);
    endfunction

endpackage : selector_pkg

// File: rtl/selector_priority_onehot.sv
// Combinational lowest-index-wins isolator: keeps only the least significant
// set bit of the request vector (two's-complement trick).
module priority_onehot
    import selector_pkg::*;
(
    input  logic [NUM_PORTS-1:0] in,
    output logic [NUM_PORTS-1:0] out
);

    logic [NUM_PORTS-1:0] neg_s;

    // Two's complement of the request vector; AND-ing it back isolates bit 0-most.
    always_comb begin
        neg_s = (~in) + SEL_ONE;
        out   = in & neg_s;
    end

endmodule : priority_onehot

// File: rtl/selector.sv
// Registered crossbar-select generator for one router output port: turns the
// five arbiter grants into a flop-driven one-hot (or idle) mux select.
module selector
    import selector_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 g00,
    input  logic                 g01,
    input  logic                 g02,
    input  logic                 g03,
    input  logic                 g04,
    output logic [NUM_PORTS-1:0] select
);

    sel_t grant_s;
    sel_t onehot_s;
    sel_t select_r;

    // Gather the named grant lines into a port-indexed vector.
    always_comb begin
        grant_s             = SEL_NONE;
        grant_s[PORT_LOCAL] = g00;
        grant_s[PORT_N]     = g01;
        grant_s[PORT_E]     = g02;
        grant_s[PORT_S]     = g03;
        grant_s[PORT_W]     = g04;
    end

    // Overlapping grants are resolved here so the register never sees multi-hot.
    priority_onehot u_priority_onehot (
        .in  (grant_s),
        .out (onehot_s)
    );

    // Select register; reset dominates, otherwise grants are sampled every edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            select_r <= SEL_NONE;
        end else begin
            select_r <= onehot_s;
        end
    end

    assign select = select_r;

endmodule : selector

// File: tb/tb_selector.sv
// Self-checking bench for selector: directed plan followed by random grants and
// resets, compared against a lowest-set-bit reference model.
module tb_selector;

    logic       clk;
    logic       rst;
    logic       g00, g01, g02, g03, g04;
    logic [4:0] select;

    int n_checks;
    int n_fails;
    logic [4:0] prev_exp;

    selector dut (
        .clk    (clk),
        .rst    (rst),
        .g00    (g00),
        .g01    (g01),
        .g02    (g02),
        .g03    (g03),
        .g04    (g04),
        .select (select)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: select=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: reset clears; otherwise the lowest-numbered granted port wins.
    function automatic logic [4:0] model(input logic r, input logic [4:0] g);
        logic [4:0] res;
        res = 5'd0;
        if (!r) begin
            for (int i = 4; i >= 0; i--) begin
                if (g[i]) res = 5'd1 << i;
            end
        end
        return res;
    endfunction

    // Apply inputs mid-cycle, confirm the output has not moved early,
    // then confirm the registered result after the next rising edge.
    task automatic step(input string tag, input logic r, input logic [4:0] g);
        logic [4:0] exp;
        @(negedge clk);
        rst = r;
        {g04, g03, g02, g01, g00} = g;
        #1;
        check_val({tag, "_pre"}, select, prev_exp);
        exp = model(r, g);
        @(posedge clk);
        #1;
        check_val(tag, select, exp);
        prev_exp = exp;
    endtask

    initial begin
        logic [4:0] g;
        logic       r;
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1;
        {g04, g03, g02, g01, g00} = 5'b11111;
        @(posedge clk);
        #1;
        check_val("reset0", select, 5'b00000);
        prev_exp = 5'b00000;

        step("reset1", 1'b1, 5'b11111);
        step("reset2", 1'b1, 5'b11111);
        step("rel_idle", 1'b0, 5'b00000);
        step("rel_idle2", 1'b0, 5'b00000);

        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 3; k++) begin
                step($sformatf("walk%0d", i), 1'b0, 5'b00001 << i);
            end
        end

        step("hold_a", 1'b0, 5'b00100);
        step("hold_b", 1'b0, 5'b00100);
        if (select !== 5'b00100) begin
            check_val("hold_abs", select, 5'b00100);
        end else begin
            check_val("hold_abs", select, 5'b00100);
        end

        step("overlap", 1'b0, 5'b10100);
        step("ovl_idle", 1'b0, 5'b00000);

        step("prio11111", 1'b0, 5'b11111);
        step("prio11110", 1'b0, 5'b11110);
        step("prio11000", 1'b0, 5'b11000);

        step("mid_g03", 1'b0, 5'b01000);
        step("mid_rst", 1'b1, 5'b01000);
        step("mid_rel", 1'b0, 5'b01000);

        for (int n = 0; n < 300; n++) begin
            r = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 2) == 0) begin
                g = 5'b00001 << $urandom_range(0, 4);
            end else begin
                g = 5'($urandom_range(0, 31));
            end
            step("rand", r, g);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_selector

// File: doc/selector.md
# selector

Registered crossbar-select generator for one output port of the 5-port NoC router. It takes the five per-input grant lines from that output port's arbiter and produces a 5-bit one-hot multiplexer select for the crossbar column. The select identifies which input port (local, N, E, S, W order by index 0..4) drives the output. It sits between the arbiter and the crossbar mux.

## Interface
- Parameters: none. Port count is fixed at 5 by the named grant ports.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high. One clock; reset is synchronous and active-high.
- g00  input  1  grant for input port 0.
- g01  input  1  grant for input port 1.
- g02  input  1  grant for input port 2.
- g03  input  1  grant for input port 3.
- g04  input  1  grant for input port 4.
- select  output  5  one-hot crossbar select; bit i set means input port i drives this output. All-zero means idle.

## Operation
- Form grant vector g = {g04, g03, g02, g01, g00}, so bit i = g0i.
- Exactly one grant set: next select = g. Example: g02 alone gives 5'b00100.
- No grant set: next select = 5'b00000. The crossbar output is idle; the previous selection is not held.
- More than one grant set (arbiter fault or overlap): fixed priority, lowest index wins. Next select has only the lowest-indexed set bit of g. Example: g02 and g04 give 5'b00100.
- select is never multi-hot. It is either one-hot or zero.
- No internal state beyond the select register. There is no round-robin pointer; fairness belongs to the arbiter.

## Timing
- select is a register output: latency of exactly 1 clk from a grant change to the select change.
- Grants sampled at rising edge N appear on select after edge N, and remain until the edge after the grants change.
- Reset: when rst=1 at a rising edge, select = 5'b00000 regardless of grants. rst has priority over grant sampling.
- On the first edge with rst=0, select reflects the grants sampled at that edge.
- Reset asserted mid-operation clears select at the next edge. There is no partial or in-flight state to recover.
- Grants that hold steady across edges keep select constant. There are no glitches, since the output comes straight from a flop.
- Inputs need no handshake. They are sampled every cycle and are assumed synchronous to clk.

## Structure
- Shared router package holds:
  - NUM_PORTS = 5
  - port index constants: PORT_LOCAL=0, PORT_N=1, PORT_E=2, PORT_S=3, PORT_W=4
  - the idle select constant SEL_NONE = 5'b00000
- One sub-module, priority_onehot: combinational NUM_PORTS-bit lowest-index-wins one-hot isolator, where out = in & (~in + 1). selector instantiates it, then registers its output.
- The crossbar mux consumes select directly. No encoding to binary is done in this block.

## Test plan
- Reset: rst=1 with all grants 1 for 2 cycles -> select=5'b00000. Release rst with all grants 0 -> select stays 5'b00000.
- Walking one-hot: drive g00, g01, g02, g03, g04 singly, one at a time, each held several cycles -> select = 00001, 00010, 00100, 01000, 10000 respectively, each one cycle after the grant.
- Hold: g02 held for two consecutive stimulus periods -> select stays 5'b00100 with no transition.
- Overlap: g02=1 and g04=1 -> select=5'b00100. Then all grants 0 -> select=5'b00000 one cycle later.
- Priority sweep: g=5'b11111 -> 00001; g=5'b11110 -> 00010; g=5'b11000 -> 01000.
- Mid-run reset: g03=1 giving select=01000, then assert rst for one cycle -> select=00000 at the next edge. Deassert rst with g03 still 1 -> 01000 on the following edge.
